branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor that produces a speculative next-PC decision, and an EX-stage resolution checker that consumes the branch comparator's taken/not-taken outcome. It combines a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. Fetch reads it combinationally every cycle. EX writes it back once per resolved branch and receives a mispredict flag and a redirect PC.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_btb.sv | 55 +++++
 rtl/branch_predictor.sv | 97 +++++++++
 tb/tb_branch_predictor.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and saturating counter helpers for the branch predictor
package bp_pkg;

  // Wide enough for the tag at the smallest legal table size (4 entries).
  localparam int TAG_MAX_W = 28;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr2_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    ctr2_e                ctr;
  } btb_entry_t;

  function automatic ctr2_e ctr_inc(input ctr2_e c);
    return (c == ST) ? ST : ctr2_e'(c + 2'd1);
  endfunction

  function automatic ctr2_e ctr_dec(input ctr2_e c);
    return (c == SNT) ? SNT : ctr2_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_btb.sv
// rtl/bp_btb.sv - direct-mapped BTB storage, two combinational read ports, one write port
module bp_btb
  import bp_pkg::*;
#(
  parameter int NUM_ENTRIES = 64,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_a_idx,
  output btb_entry_t       rd_a_entry,
  input  logic [IDX_W-1:0] rd_b_idx,
  output btb_entry_t       rd_b_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  logic                 valid_q  [NUM_ENTRIES];
  ctr2_e                ctr_q    [NUM_ENTRIES];
  logic [TAG_MAX_W-1:0] tag_q    [NUM_ENTRIES];
  logic [31:0]          target_q [NUM_ENTRIES];

  // Valid bits and counters carry reset state; tag/target are don't-care until allocated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
      ctr_q[wr_idx]   <= wr_entry.ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
    end
  end

  always_comb begin
    rd_a_entry.valid  = valid_q[rd_a_idx];
    rd_a_entry.tag    = tag_q[rd_a_idx];
    rd_a_entry.target = target_q[rd_a_idx];
    rd_a_entry.ctr    = ctr_q[rd_a_idx];
    rd_b_entry.valid  = valid_q[rd_b_idx];
    rd_b_entry.tag    = tag_q[rd_b_idx];
    rd_b_entry.target = target_q[rd_b_idx];
    rd_b_entry.ctr    = ctr_q[rd_b_idx];
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB + 2-bit counter predictor with EX-stage resolve and statistics
module branch_predictor
  import bp_pkg::*;
#(
  parameter int NUM_ENTRIES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_fetch_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_count,
  output logic [31:0] o_miss_count
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [IDX_W-1:0]     fetch_idx, upd_idx;
  logic [TAG_MAX_W-1:0] fetch_tag, upd_tag;
  btb_entry_t           fetch_entry, upd_entry, wr_entry;
  logic                 fetch_hit, upd_hit, wr_en;
  logic [31:0]          br_count_q, miss_count_q;

  assign fetch_idx = i_fetch_pc[IDX_W+1:2];
  assign upd_idx   = i_upd_pc[IDX_W+1:2];
  assign fetch_tag = TAG_MAX_W'(i_fetch_pc >> (IDX_W + 2));
  assign upd_tag   = TAG_MAX_W'(i_upd_pc >> (IDX_W + 2));

  bp_btb #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_btb (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .rd_a_idx   (fetch_idx),
    .rd_a_entry (fetch_entry),
    .rd_b_idx   (upd_idx),
    .rd_b_entry (upd_entry),
    .wr_en      (wr_en),
    .wr_idx     (upd_idx),
    .wr_entry   (wr_entry)
  );

  assign fetch_hit     = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
  assign o_pred_taken  = fetch_hit && fetch_entry.ctr[1];
  assign o_pred_target = o_pred_taken ? fetch_entry.target : i_fetch_pc + 32'd4;

  assign upd_hit = upd_entry.valid && (upd_entry.tag == upd_tag);

  always_comb begin
    o_mispredict  = 1'b0;
    o_redirect_pc = 32'd0;
    if (i_upd_valid) begin
      o_mispredict  = (i_upd_taken != i_upd_pred_taken) ||
                      (i_upd_taken && i_upd_pred_taken && (i_upd_target != i_upd_pred_target));
      o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;
    end
  end

  // Not-taken misses are never allocated so cold fall-through code does not evict hot branches.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = upd_entry;
    if (i_upd_valid) begin
      if (upd_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = i_upd_taken ? ctr_inc(upd_entry.ctr) : ctr_dec(upd_entry.ctr);
        if (i_upd_taken) wr_entry.target = i_upd_target;
      end else if (i_upd_taken) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: upd_tag, target: i_upd_target, ctr: WT};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      br_count_q   <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      if (i_upd_valid)  br_count_q   <= br_count_q + 32'd1;
      if (o_mispredict) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign o_br_count   = br_count_q;
  assign o_miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector bench for branch_predictor
module tb_branch_predictor;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_fetch_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_pred_taken;
  logic [31:0] i_upd_pred_target;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic [31:0] o_br_count;
  logic [31:0] o_miss_count;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.NUM_ENTRIES(64)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_fetch_pc        (i_fetch_pc),
    .o_pred_taken      (o_pred_taken),
    .o_pred_target     (o_pred_target),
    .i_upd_valid       (i_upd_valid),
    .i_upd_pc          (i_upd_pc),
    .i_upd_taken       (i_upd_taken),
    .i_upd_target      (i_upd_target),
    .i_upd_pred_taken  (i_upd_pred_taken),
    .i_upd_pred_target (i_upd_pred_target),
    .o_mispredict      (o_mispredict),
    .o_redirect_pc     (o_redirect_pc),
    .o_br_count        (o_br_count),
    .o_miss_count      (o_miss_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] fetch_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic        exp_mis;
    logic [31:0] exp_redirect;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive_upd(input logic v, input logic [31:0] pc, input logic t,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    i_upd_valid       = v;
    i_upd_pc          = pc;
    i_upd_taken       = t;
    i_upd_target      = tgt;
    i_upd_pred_taken  = pt;
    i_upd_pred_target = ptgt;
  endtask

  initial begin
    // 0x100 and 0x200 share index 0 with tags 1 and 2; 0x400 is tag 4 at index 0.
    vecs[0]  = '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h104,  1'b0, 32'h0};
    vecs[1]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h80,   1'b0, 32'h0,    1'b0, 32'h104,  1'b1, 32'h80};
    vecs[2]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h80,   1'b1, 32'h80,   1'b1, 32'h80,   1'b0, 32'h80};
    vecs[3]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h80,   1'b1, 32'h80,   1'b1, 32'h80,   1'b0, 32'h80};
    vecs[4]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h80,   1'b1, 32'h80,   1'b1, 32'h80,   1'b0, 32'h80};
    vecs[5]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h80,   1'b1, 32'h80,   1'b1, 32'h80,   1'b0, 32'h80};
    vecs[6]  = '{32'h100, 1'b1, 32'h100, 1'b0, 32'h0,    1'b1, 32'h80,   1'b1, 32'h80,   1'b1, 32'h104};
    vecs[7]  = '{32'h100, 1'b1, 32'h100, 1'b0, 32'h0,    1'b1, 32'h80,   1'b1, 32'h80,   1'b1, 32'h104};
    vecs[8]  = '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h104,  1'b0, 32'h0};
    vecs[9]  = '{32'h100, 1'b1, 32'h100, 1'b1, 32'h90,   1'b1, 32'h80,   1'b0, 32'h104,  1'b1, 32'h90};
    vecs[10] = '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h90,   1'b0, 32'h0};
    vecs[11] = '{32'h200, 1'b1, 32'h200, 1'b1, 32'h300,  1'b0, 32'h0,    1'b0, 32'h204,  1'b1, 32'h300};
    vecs[12] = '{32'h100, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h104,  1'b0, 32'h0};
    vecs[13] = '{32'h200, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h300,  1'b0, 32'h0};
    vecs[14] = '{32'h10,  1'b1, 32'h400, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h14,   1'b0, 32'h404};
    vecs[15] = '{32'h200, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h300,  1'b0, 32'h0};
    vecs[16] = '{32'h400, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h404,  1'b0, 32'h0};
    vecs[17] = '{32'h84,  1'b1, 32'h84,  1'b1, 32'h1000, 1'b0, 32'h0,    1'b0, 32'h88,   1'b1, 32'h1000};
    vecs[18] = '{32'h84,  1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h1000, 1'b0, 32'h0};

    i_reset    = 1'b0;
    i_fetch_pc = 32'h100;
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    #2;
    check("reset_br_count", o_br_count, 32'd0);
    check("reset_miss_count", o_miss_count, 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge i_clk);
      i_fetch_pc = vecs[i].fetch_pc;
      drive_upd(vecs[i].upd_valid, vecs[i].upd_pc, vecs[i].taken, vecs[i].target,
                vecs[i].pred_taken, vecs[i].pred_target);
      #2;
      check($sformatf("v%0d_pred_taken", i), {31'd0, o_pred_taken}, {31'd0, vecs[i].exp_taken});
      check($sformatf("v%0d_pred_target", i), o_pred_target, vecs[i].exp_target);
      check($sformatf("v%0d_mispredict", i), {31'd0, o_mispredict}, {31'd0, vecs[i].exp_mis});
      check($sformatf("v%0d_redirect", i), o_redirect_pc, vecs[i].exp_redirect);
    end

    @(negedge i_clk);
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    check("table_br_count", o_br_count, 32'd11);
    check("table_miss_count", o_miss_count, 32'd6);

    // Miss counter wrap: backdoor preload, then one mispredict.
    dut.miss_count_q = 32'hFFFF_FFFF;
    drive_upd(1'b1, 32'h84, 1'b0, 32'h0, 1'b1, 32'h1000);
    #1;
    check("wrap_mispredict", {31'd0, o_mispredict}, 32'd1);
    @(negedge i_clk);
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    check("wrap_miss_count", o_miss_count, 32'd0);
    check("wrap_br_count", o_br_count, 32'd12);

    // Asynchronous reset mid-cycle with an in-flight update.
    @(negedge i_clk);
    i_fetch_pc = 32'h200;
    drive_upd(1'b1, 32'h84, 1'b1, 32'h2000, 1'b0, 32'h0);
    #1;
    check("pre_reset_pred_taken", {31'd0, o_pred_taken}, 32'd1);
    #1;
    i_reset = 1'b0;
    #1;
    check("async_br_count", o_br_count, 32'd0);
    check("async_miss_count", o_miss_count, 32'd0);
    check("async_pred_taken", {31'd0, o_pred_taken}, 32'd0);
    check("async_pred_target", o_pred_target, 32'h204);
    check("async_mispredict", {31'd0, o_mispredict}, 32'd1);
    check("async_redirect", o_redirect_pc, 32'h2000);
    @(negedge i_clk);
    drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    i_reset    = 1'b1;
    i_fetch_pc = 32'h84;
    #2;
    check("post_reset_pred_taken", {31'd0, o_pred_taken}, 32'd0);
    check("post_reset_pred_target", o_pred_target, 32'h88);
    check("post_reset_br_count", o_br_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
